// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reset/lock/phase-shift sequencer.
// Contents: sequencer state enum, command error codes, width helpers.
package pll_ctrl_pkg;

  typedef enum logic [2:0] {
    RST_HOLD,
    WAIT_LOCK,
    READY,
    STEP_HI,
    WAIT_DN,
    WAIT_UP,
    GAP
  } state_e;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DN_TO = 2'd1;
  localparam logic [1:0] ERR_UP_TO = 2'd2;
  localparam logic [1:0] ERR_LOCK  = 2'd3;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Bits needed to count 0 .. n-1 (at least 1).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic is_cmd_state(input state_e s);
    return (s == STEP_HI) || (s == WAIT_DN) || (s == WAIT_UP) || (s == GAP);
  endfunction

endpackage

// File: rtl/pll_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
// Ports: i_clk destination clock, i_rst async active-high reset (output clears to 0),
//        i_d asynchronous input, o_q synchronized output.
module pll_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL reset / lock-qualification sequencer and dynamic phase-shift controller (scanclk domain).
// Ports: i_clk, i_areset (async, active high); i_pll_locked / i_pll_phasedone (async from PLL);
//        o_pll_areset, o_pll_phasestep, o_pll_phaseupdown, o_pll_phasecounterselect (to PLL);
//        i_cmd_req/sel/dir/steps command in; o_cmd_ack/done/err one-cycle pulses;
//        o_err_code (held until next ack), o_steps_done, o_ready, o_busy.
module pll_phase_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int unsigned CNT_SEL_W    = 3,
  parameter int unsigned STEP_W       = 8,
  parameter int unsigned RESET_CYCLES = 16,
  parameter int unsigned LOCK_STABLE  = 1024,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned PS_HIGH      = 2,
  parameter int unsigned DONE_TIMEOUT = 64
) (
  input  logic                 i_clk,
  input  logic                 i_areset,
  input  logic                 i_pll_locked,
  input  logic                 i_pll_phasedone,
  output logic                 o_pll_areset,
  output logic                 o_pll_phasestep,
  output logic                 o_pll_phaseupdown,
  output logic [CNT_SEL_W-1:0] o_pll_phasecounterselect,
  input  logic                 i_cmd_req,
  input  logic [CNT_SEL_W-1:0] i_cmd_sel,
  input  logic                 i_cmd_dir,
  input  logic [STEP_W-1:0]    i_cmd_steps,
  output logic                 o_cmd_ack,
  output logic                 o_cmd_done,
  output logic                 o_cmd_err,
  output logic [1:0]           o_err_code,
  output logic [STEP_W-1:0]    o_steps_done,
  output logic                 o_ready,
  output logic                 o_busy
);

  // One shared cycle counter serves every timed state; size it for the longest.
  localparam int unsigned CNT_MAX = max2(max2(LOCK_TIMEOUT, RESET_CYCLES),
                                         max2(DONE_TIMEOUT, PS_HIGH));
  localparam int unsigned CNT_W   = cnt_width(CNT_MAX);
  localparam int unsigned STB_W   = cnt_width(LOCK_STABLE);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PS_LAST   = CNT_W'(PS_HIGH - 1);
  localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [STB_W-1:0] STB_LAST  = STB_W'(LOCK_STABLE - 1);

  logic w_lk_s;
  logic w_pd_s;

  state_e               r_state,      w_state_nxt;
  logic [CNT_W-1:0]     r_cnt,        w_cnt_nxt;
  logic [STB_W-1:0]     r_stable,     w_stable_nxt;
  logic [CNT_SEL_W-1:0] r_sel,        w_sel_nxt;
  logic                 r_dir,        w_dir_nxt;
  logic [STEP_W-1:0]    r_steps,      w_steps_nxt;
  logic [STEP_W-1:0]    r_steps_done, w_steps_done_nxt;
  logic                 r_ack,        w_ack_nxt;
  logic                 r_done,       w_done_nxt;
  logic                 r_err,        w_err_nxt;
  logic [1:0]           r_err_code,   w_err_code_nxt;
  logic [STEP_W-1:0]    w_steps_inc;

  pll_sync2 u_sync_lock (
    .i_clk (i_clk),
    .i_rst (i_areset),
    .i_d   (i_pll_locked),
    .o_q   (w_lk_s)
  );

  pll_sync2 u_sync_done (
    .i_clk (i_clk),
    .i_rst (i_areset),
    .i_d   (i_pll_phasedone),
    .o_q   (w_pd_s)
  );

  assign w_steps_inc = r_steps_done + STEP_W'(1);

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      r_state      <= RST_HOLD;
      r_cnt        <= '0;
      r_stable     <= '0;
      r_sel        <= '0;
      r_dir        <= 1'b0;
      r_steps      <= '0;
      r_steps_done <= '0;
      r_ack        <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_err_code   <= ERR_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_stable     <= w_stable_nxt;
      r_sel        <= w_sel_nxt;
      r_dir        <= w_dir_nxt;
      r_steps      <= w_steps_nxt;
      r_steps_done <= w_steps_done_nxt;
      r_ack        <= w_ack_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_err_code   <= w_err_code_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt + CNT_W'(1);
    w_stable_nxt     = r_stable;
    w_sel_nxt        = r_sel;
    w_dir_nxt        = r_dir;
    w_steps_nxt      = r_steps;
    w_steps_done_nxt = r_steps_done;
    w_ack_nxt        = 1'b0;
    w_done_nxt       = 1'b0;
    w_err_nxt        = 1'b0;
    w_err_code_nxt   = r_err_code;

    unique case (r_state)
      RST_HOLD: begin
        if (r_cnt == RST_LAST) begin
          w_state_nxt  = WAIT_LOCK;
          w_cnt_nxt    = '0;
          w_stable_nxt = '0;
        end
      end
      WAIT_LOCK: begin
        // Stability run and overall timeout are independent: a lock that keeps
        // chattering still ends in a fresh PLL reset.
        w_stable_nxt = w_lk_s ? r_stable + STB_W'(1) : '0;
        if (w_lk_s && (r_stable == STB_LAST)) begin
          w_state_nxt = READY;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LOCK_LAST) begin
          w_state_nxt = RST_HOLD;
          w_cnt_nxt   = '0;
        end
      end
      READY: begin
        w_cnt_nxt = '0;
        if (!w_lk_s) begin
          w_state_nxt  = WAIT_LOCK;
          w_stable_nxt = '0;
        end else if (i_cmd_req) begin
          w_state_nxt      = STEP_HI;
          w_ack_nxt        = 1'b1;
          w_sel_nxt        = i_cmd_sel;
          w_dir_nxt        = i_cmd_dir;
          w_steps_nxt      = i_cmd_steps;
          w_steps_done_nxt = '0;
          w_err_code_nxt   = ERR_NONE;
        end
      end
      STEP_HI: begin
        // A zero-step command passes through here once without raising phasestep,
        // so done lands exactly one cycle after ack.
        if (r_steps == '0) begin
          w_state_nxt = READY;
          w_done_nxt  = 1'b1;
        end else if (r_cnt == PS_LAST) begin
          w_state_nxt = WAIT_DN;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_DN: begin
        if (!w_pd_s) begin
          w_state_nxt = WAIT_UP;
          w_cnt_nxt   = '0;
        end else if (r_cnt == DONE_LAST) begin
          w_state_nxt    = RST_HOLD;
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_DN_TO;
        end
      end
      WAIT_UP: begin
        if (w_pd_s) begin
          w_steps_done_nxt = w_steps_inc;
          if (w_steps_inc == r_steps) begin
            w_state_nxt = READY;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = GAP;
          end
        end else if (r_cnt == DONE_LAST) begin
          w_state_nxt    = RST_HOLD;
          w_cnt_nxt      = '0;
          w_err_nxt      = 1'b1;
          w_err_code_nxt = ERR_UP_TO;
        end
      end
      GAP: begin
        w_state_nxt = STEP_HI;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = RST_HOLD;
        w_cnt_nxt   = '0;
      end
    endcase

    // Lock loss overrides whatever the command states decided this cycle,
    // including a same-cycle phasedone edge.
    if (is_cmd_state(r_state) && !w_lk_s) begin
      w_state_nxt      = WAIT_LOCK;
      w_cnt_nxt        = '0;
      w_stable_nxt     = '0;
      w_steps_done_nxt = r_steps_done;
      w_done_nxt       = 1'b0;
      w_err_nxt        = 1'b1;
      w_err_code_nxt   = ERR_LOCK;
    end
  end

  assign o_pll_areset             = (r_state == RST_HOLD);
  assign o_pll_phasestep          = (r_state == STEP_HI) && (r_steps != '0);
  assign o_pll_phaseupdown        = r_dir;
  assign o_pll_phasecounterselect = r_sel;
  assign o_cmd_ack                = r_ack;
  assign o_cmd_done               = r_done;
  assign o_cmd_err                = r_err;
  assign o_err_code               = r_err_code;
  assign o_steps_done             = r_steps_done;
  assign o_ready                  = (r_state == READY);
  assign o_busy                   = is_cmd_state(r_state);

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Self-checking bench for pll_phase_ctrl: bring-up timing, table of shift commands with a
// scoreboard of expected completions, lock loss and async reset sequences.
module tb_pll_phase_ctrl;

  localparam int unsigned SEL_W  = 3;
  localparam int unsigned STEP_W = 8;

  logic              clk    = 1'b0;
  logic              areset = 1'b1;
  logic              locked = 1'b0;
  logic              pd     = 1'b1;
  logic              req    = 1'b0;
  logic [SEL_W-1:0]  sel    = '0;
  logic              dir    = 1'b0;
  logic [STEP_W-1:0] steps  = '0;

  logic              o_pll_areset, o_pll_phasestep, o_pll_phaseupdown;
  logic [SEL_W-1:0]  o_pll_phasecounterselect;
  logic              o_cmd_ack, o_cmd_done, o_cmd_err, o_ready, o_busy;
  logic [1:0]        o_err_code;
  logic [STEP_W-1:0] o_steps_done;

  pll_phase_ctrl #(
    .CNT_SEL_W    (SEL_W),
    .STEP_W       (STEP_W),
    .RESET_CYCLES (16),
    .LOCK_STABLE  (1024),
    .LOCK_TIMEOUT (65536),
    .PS_HIGH      (2),
    .DONE_TIMEOUT (64)
  ) u_dut (
    .i_clk                    (clk),
    .i_areset                 (areset),
    .i_pll_locked             (locked),
    .i_pll_phasedone          (pd),
    .o_pll_areset             (o_pll_areset),
    .o_pll_phasestep          (o_pll_phasestep),
    .o_pll_phaseupdown        (o_pll_phaseupdown),
    .o_pll_phasecounterselect (o_pll_phasecounterselect),
    .i_cmd_req                (req),
    .i_cmd_sel                (sel),
    .i_cmd_dir                (dir),
    .i_cmd_steps              (steps),
    .o_cmd_ack                (o_cmd_ack),
    .o_cmd_done               (o_cmd_done),
    .o_cmd_err                (o_cmd_err),
    .o_err_code               (o_err_code),
    .o_steps_done             (o_steps_done),
    .o_ready                  (o_ready),
    .o_busy                   (o_busy)
  );

  always #5 clk = ~clk;

  // mode: 0 normal phasedone handshake, 1 phasedone stuck high, 2 phasedone stuck low
  typedef struct {
    int sel; int dir; int steps; int mode;
    int is_err; int code; int sd; int pulses; int lat; int to;
  } vec_t;

  vec_t sb_q[$];
  vec_t vecs[7];

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int run      = 0;
  int last_fall = 0;
  int ack_cyc  = 0;
  int rst_run  = 0;
  int rst_len  = 0;
  int n_compl  = 0;
  int cur_sel  = 0;
  int cur_dir  = 0;
  int pd_mode  = 0;
  bit stable_bad = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // PLL model: phasedone drops 2 cycles after phasestep falls and returns 4 cycles later.
  initial forever begin
    @(negedge o_pll_phasestep);
    if (pd_mode != 1) begin
      repeat (2) @(posedge clk);
      #1 pd = 1'b0;
      repeat ((pd_mode == 0) ? 4 : 200) @(posedge clk);
      #1 pd = 1'b1;
    end
  end

  // Monitor: pulse widths, select/direction stability, scoreboard pops on completion.
  initial forever begin
    vec_t e;
    @(negedge clk);
    if (o_cmd_ack) begin
      pulses     = 0;
      run        = 0;
      stable_bad = 1'b0;
      ack_cyc    = cyc;
      chk("ack_done_overlap", int'(o_cmd_done), 0);
    end
    if (o_busy && (int'(o_pll_phasecounterselect) != cur_sel || int'(o_pll_phaseupdown) != cur_dir))
      stable_bad = 1'b1;
    if (o_pll_phasestep) run++;
    else if (run > 0) begin
      chk("ps_width", run, 2);
      pulses++;
      last_fall = cyc;
      run = 0;
    end
    if (o_pll_areset) rst_run++;
    else if (rst_run > 0) begin
      rst_len = rst_run;
      rst_run = 0;
    end
    if (o_cmd_done || o_cmd_err) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_errs++;
        $display("FAIL completion_unexpected: done=%0d err=%0d with no command pending",
                 o_cmd_done, o_cmd_err);
      end else begin
        e = sb_q.pop_front();
        chk("kind_is_err", int'(o_cmd_err), e.is_err);
        chk("err_code", int'(o_err_code), e.code);
        chk("steps_done", int'(o_steps_done), e.sd);
        chk("pulse_count", pulses, e.pulses);
        chk("sel_dir_stable", int'(stable_bad), 0);
        chk("busy_clear", int'(o_busy), 0);
        if (e.lat >= 0) chk("ack_to_done", cyc - ack_cyc, e.lat);
        if (e.to >= 0) chk("dn_timeout", cyc - last_fall, e.to);
      end
      n_compl++;
    end
  end

  task automatic wait_ready(input string name, input int limit);
    bit got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (o_ready) begin
        got = 1'b1;
        break;
      end
    end
    chk(name, int'(got), 1);
  endtask

  task automatic do_cmd(input vec_t v, input bit push);
    bit got = 1'b0;
    wait_ready("ready_before_cmd", 3000);
    cur_sel = v.sel;
    cur_dir = v.dir;
    pd_mode = v.mode;
    if (push) sb_q.push_back(v);
    sel   = 3'(v.sel);
    dir   = v.dir[0];
    steps = 8'(v.steps);
    req   = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (o_cmd_ack) begin
        got = 1'b1;
        break;
      end
    end
    req = 1'b0;
    chk("ack_seen", int'(got), 1);
  endtask

  task automatic wait_compl(input int n0, input int limit);
    bit got = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk);
      #1;
      if (n_compl != n0) begin
        got = 1'b1;
        break;
      end
    end
    chk("completion_seen", int'(got), 1);
  endtask

  initial begin
    int   rel, areset_low, ready_k, n0;
    bit   got;
    vec_t v;

    //          sel dir steps mode err code sd pulses lat  to
    vecs[0] = '{2,  1,  3,    0,   0,  0,   3, 3,     -1, -1};
    vecs[1] = '{0,  0,  0,    0,   0,  0,   0, 0,     1,  -1};
    vecs[2] = '{5,  0,  1,    0,   0,  0,   1, 1,     -1, -1};
    vecs[3] = '{1,  1,  2,    1,   1,  1,   0, 1,     -1, 64};
    vecs[4] = '{7,  1,  2,    0,   0,  0,   2, 2,     -1, -1};
    vecs[5] = '{3,  0,  4,    2,   1,  2,   0, 1,     -1, -1};
    vecs[6] = '{4,  0,  6,    0,   0,  0,   6, 6,     -1, -1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pll_areset", int'(o_pll_areset), 1);
    chk("rst_phasestep", int'(o_pll_phasestep), 0);
    chk("rst_ready", int'(o_ready), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_steps_done", int'(o_steps_done), 0);
    chk("rst_err_code", int'(o_err_code), 0);

    // Bring-up: locked rises at cycle 100
    areset_low = -1;
    ready_k    = -1;
    @(posedge clk);
    #1 areset = 1'b0;
    rel = cyc;
    for (int k = 0; k < 1400; k++) begin
      @(posedge clk);
      #1;
      if (cyc - rel == 100) locked = 1'b1;
      @(negedge clk);
      if (areset_low < 0 && !o_pll_areset) areset_low = cyc - rel;
      if (o_ready) begin
        ready_k = cyc - rel;
        break;
      end
    end
    chk("areset_release_cycle", areset_low, 16);
    chk_range("bringup_ready_cycle", ready_k, 1125, 1127);

    // Command table
    for (int i = 0; i < 7; i++) begin
      rst_len = 0;
      n0 = n_compl;
      do_cmd(vecs[i], 1'b1);
      wait_compl(n0, 3000);
      if (vecs[i].mode != 0) begin
        got = 1'b0;
        for (int k = 0; k < 100; k++) begin
          @(negedge clk);
          if (!o_pll_areset) begin
            got = 1'b1;
            break;
          end
        end
        @(posedge clk);
        #1;
        chk("abort_areset_ended", int'(got), 1);
        chk("abort_areset_len", rst_len, 16);
      end
    end

    // Lock loss during the 2nd of 5 steps
    v = '{3, 1, 5, 0, 1, 3, 1, 2, -1, -1};
    n0 = n_compl;
    do_cmd(v, 1'b1);
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (pulses == 1 && o_pll_phasestep) begin
        got = 1'b1;
        break;
      end
    end
    chk("second_step_started", int'(got), 1);
    locked = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("lockloss_phasestep_low", int'(o_pll_phasestep), 0);
    wait_compl(n0, 200);
    repeat (20) @(posedge clk);
    #1 locked = 1'b1;
    wait_ready("ready_after_relock", 1500);

    // Async reset while in WAIT_UP of the 2nd step
    v = '{6, 1, 4, 0, 0, 0, 4, 4, -1, -1};
    n0 = n_compl;
    do_cmd(v, 1'b0);
    got = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (pulses == 2) begin
        got = 1'b1;
        break;
      end
    end
    chk("second_step_ended", int'(got), 1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("pre_reset_busy", int'(o_busy), 1);
    chk("pre_reset_steps_done", int'(o_steps_done), 1);
    areset = 1'b1;
    #1;
    chk("mid_rst_pll_areset", int'(o_pll_areset), 1);
    chk("mid_rst_phasestep", int'(o_pll_phasestep), 0);
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_ready", int'(o_ready), 0);
    chk("mid_rst_steps_done", int'(o_steps_done), 0);
    chk("mid_rst_sel", int'(o_pll_phasecounterselect), 0);
    chk("mid_rst_updown", int'(o_pll_phaseupdown), 0);
    chk("mid_rst_cmd_err", int'(o_cmd_err), 0);
    repeat (5) @(posedge clk);
    #1 areset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("no_completion_after_reset", n_compl, n0);
    wait_ready("ready_after_async_reset", 1500);

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule

// File: doc/pll_phase_ctrl.md
Name: pll_phase_ctrl

Overview:
- Sequencer for the PLL's reset and lock qualification, and for its dynamic phase-shift port.
- Runs in the PLL's scanclk domain.
- Drives the PLL's areset, phasestep, phaseupdown and phasecounterselect, and monitors locked and phasedone.
- Gives the SDR control logic a single req/ack command interface: "shift counter N by K steps up/down".

Parameters:
- CNT_SEL_W, 3, width of phasecounterselect.
- STEP_W, 8, width of the step-count field; 0 steps is legal and completes immediately.
- RESET_CYCLES, 16, cycles pll_areset is held high per reset pulse.
- LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before ready.
- LOCK_TIMEOUT, 65536, cycles in WAIT_LOCK before re-pulsing pll_areset.
- PS_HIGH, 2, cycles phasestep is held high per step (minimum 2).
- DONE_TIMEOUT, 64, cycles allowed for each phasedone edge.

Ports:
- clk  in  1  block clock, same net as PLL scanclk.
- areset  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked; asynchronous to clk.
- pll_phasedone  in  1  PLL phasedone; asynchronous to clk.
- pll_areset  out  1  to PLL areset.
- pll_phasestep  out  1  to PLL phasestep.
- pll_phaseupdown  out  1  to PLL phaseupdown; 1 = up.
- pll_phasecounterselect  out  CNT_SEL_W  to PLL phasecounterselect.
- cmd_req  in  1  command request, level.
- cmd_sel  in  CNT_SEL_W  counter to shift.
- cmd_dir  in  1  1 = up, 0 = down.
- cmd_steps  in  STEP_W  number of steps.
- cmd_ack  out  1  one-cycle pulse: command accepted.
- cmd_done  out  1  one-cycle pulse: command finished, all steps done.
- cmd_err  out  1  one-cycle pulse: command aborted.
- err_code  out  2  valid with cmd_err; held until next ack.
- steps_done  out  STEP_W  steps completed in current/last command.
- ready  out  1  PLL qualified, no command active.
- busy  out  1  command in progress.

Behaviour:
- Reset values:
  - pll_areset = 1, so the PLL is held in reset during areset.
  - All other outputs = 0, err_code = 0, steps_done = 0.
  - State = RST_HOLD with its counter cleared.
- Synchronizers: pll_locked and pll_phasedone each pass through 2 flops. All logic uses only the synchronized versions (lk_s, pd_s).
- RST_HOLD:
  - pll_areset = 1 for RESET_CYCLES cycles, then 0 and go to WAIT_LOCK.
- WAIT_LOCK:
  - A counter counts consecutive lk_s = 1 cycles and clears on lk_s = 0.
  - At LOCK_STABLE go to READY.
  - An independent timeout reaching LOCK_TIMEOUT goes to RST_HOLD.
- READY:
  - ready = 1.
  - lk_s = 0 goes to WAIT_LOCK, with no err pulse.
  - cmd_req = 1 (and lk_s = 1): pulse cmd_ack and latch sel/dir/steps.
  - Drive pll_phasecounterselect and pll_phaseupdown from the latched values and hold them stable until the command ends.
  - Clear steps_done and set busy = 1.
  - If steps = 0: pulse cmd_done in the next cycle and return to READY. Otherwise go to STEP_HI.
  - A request arriving while not READY is held pending; the requester keeps cmd_req high until ack.
- STEP_HI:
  - pll_phasestep = 1 for exactly PS_HIGH cycles, then 0 and go to WAIT_DN.
- WAIT_DN:
  - Wait for pd_s = 0, then go to WAIT_UP.
  - Timeout DONE_TIMEOUT triggers abort with err_code = 1.
- WAIT_UP:
  - Wait for pd_s = 1, then increment steps_done.
  - If steps_done now equals the latched steps: pulse cmd_done, busy = 0, go to READY.
  - Otherwise go to GAP.
  - Timeout DONE_TIMEOUT triggers abort with err_code = 2.
- GAP:
  - One idle cycle with phasestep low, then STEP_HI.
- Loss of lock during any command state:
  - Takes priority over the same-cycle phasedone transition.
  - Force phasestep = 0, pulse cmd_err with err_code = 3, busy = 0, go to WAIT_LOCK.
- Abort on timeout:
  - phasestep = 0, cmd_err pulse, busy = 0, go to RST_HOLD, which re-resets the PLL.
- Counter widths: steps_done never wraps, because it terminates at the latched steps value (≤ 2^STEP_W − 1).
- areset asserted mid-command: immediate return to reset values, with no cmd_err pulse.
- Exactly one of cmd_done / cmd_err fires per ack. ack and done can never coincide: done comes at least 1 cycle after ack.

Decomposition:
- Shared package pll_ctrl_pkg:
  - State enum {RST_HOLD, WAIT_LOCK, READY, STEP_HI, WAIT_DN, WAIT_UP, GAP}.
  - Error codes ERR_NONE = 0, ERR_DN_TO = 1, ERR_UP_TO = 2, ERR_LOCK = 3.
- One sub-module, pll_sync2: 2-flop synchronizer with async active-high reset to 0, instantiated twice.

Test Plan:
- Bring-up:
  - Stimulus: release areset; pll_locked rises at cycle 100, RESET_CYCLES = 16, LOCK_STABLE = 1024.
  - Required: pll_areset low at cycle 16; ready = 1 at 100 + 2 + 1024 (±1).
- 3-step shift:
  - Stimulus: cmd sel = 2, dir = 1, steps = 3. PLL model drops phasedone 2 cycles after phasestep falls and restores it 4 cycles later.
  - Required: three 2-cycle phasestep pulses; sel = 2 and updown = 1 stable throughout; cmd_done once; steps_done = 3.
- Zero steps:
  - Stimulus: steps = 0.
  - Required: ack, then cmd_done the next cycle, no phasestep activity.
- phasedone stuck high:
  - Stimulus: phasedone never falls.
  - Required: cmd_err with err_code = 1 at 64 cycles after WAIT_DN entry; pll_areset pulses 16 cycles.
- Lock loss:
  - Stimulus: drop pll_locked during the 2nd step of 5.
  - Required: phasestep = 0 within 3 cycles; cmd_err with err_code = 3; steps_done = 1; ready returns after lock restabilizes.
- Async reset mid-command:
  - Stimulus: assert areset while in WAIT_UP.
  - Required: all outputs at reset values immediately, pll_areset = 1, no cmd_err.
